deserializer_fsm: RTL and testbench
===================================

DESERIALIZER_FSM -- requirements
Module: deserializer_fsm

Interface
REQ-001 SHALL have parameter LENGTH, default 24: word width in bits, legal range >= 2.
REQ-002 SHALL have parameter LSB_FIRST, default 1: 1 = first received bit lands in bit 0; 0 = first received bit lands in bit LENGTH-1.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port i_en, input, 1 bit: clock enable; when low, all registers hold.
REQ-006 SHALL have port i_din, input, 1 bit: serial data bit from the upstream serializer.
REQ-007 SHALL have port i_din_valid, input, 1 bit: i_din is valid.
REQ-008 SHALL have port o_ready, output, 1 bit: block accepts a serial bit this cycle.
REQ-009 SHALL have port ov_dout, output, LENGTH bits: assembled parallel word.
REQ-010 SHALL have port o_dout_valid, output, 1 bit: ov_dout holds a complete word.
REQ-011 SHALL have port i_ready, input, 1 bit: downstream consumes ov_dout this cycle.
REQ-012 SHALL have port ov_bit_count, output, $clog2(LENGTH)+1 bits: bits received into the current word.

Function
REQ-013 SHALL implement a two-state FSM: S_RECV (collecting bits) and S_HOLD (word presented).
REQ-014 SHALL define a bit transfer as a rising edge with i_en=1, state S_RECV, i_din_valid=1 and o_ready=1.
REQ-015 SHALL drive o_ready = ready_reg AND i_en, where ready_reg is registered high in S_RECV and low in S_HOLD.
REQ-016 On each bit transfer, SHALL shift i_din into the internal shift register: LSB_FIRST=1 inserts at bit LENGTH-1 and shifts right; LSB_FIRST=0 inserts at bit 0 and shifts left.
REQ-017 On each bit transfer, SHALL increment ov_bit_count by 1.
REQ-018 Cycles with i_din_valid=0 in S_RECV SHALL leave the shift register and ov_bit_count unchanged, so gaps between bits are allowed.
REQ-019 On the transfer that brings the count to LENGTH, SHALL on the same edge:
  - load ov_dout with the completed word;
  - set o_dout_valid=1;
  - clear ready_reg;
  - reset ov_bit_count to 0;
  - enter S_HOLD.
REQ-020 Latency SHALL be one cycle: o_dout_valid rises on the edge of the LENGTH-th transfer.
REQ-021 In S_HOLD, SHALL hold ov_dout stable and keep o_dout_valid=1 until a rising edge with i_en=1 and i_ready=1.
REQ-022 On that edge, SHALL clear o_dout_valid, set ready_reg and return to S_RECV; the next bit can transfer one cycle later.
REQ-023 In S_HOLD, SHALL ignore i_din and i_din_valid; no bit is lost, because o_ready=0.
REQ-024 i_ready while in S_RECV SHALL have no effect.
REQ-025 ov_dout SHALL change only on word completion; between words it holds the last word.
REQ-026 With i_en=0, SHALL update no register and perform no transfer, regardless of i_din_valid or i_ready.
REQ-027 Unreachable FSM encodings SHALL return to S_RECV on the next enabled edge.

Reset
REQ-028 While i_rst_n=0, SHALL asynchronously force:
  - state = S_RECV;
  - ready_reg = 1 (o_ready = i_en);
  - o_dout_valid = 0;
  - ov_dout = 0;
  - shift register = 0;
  - ov_bit_count = 0.
REQ-029 Reset asserted mid-word or in S_HOLD SHALL discard the partial or pending word, with no o_dout_valid pulse afterward.
REQ-030 After i_rst_n deasserts, the first bit transfer SHALL be possible on the first enabled edge.

Verification
REQ-031 LENGTH=24, LSB_FIRST=1, stream 0xA5C3F1 LSB-first with i_din_valid constantly 1 and i_ready=1 -> o_dout_valid=1 and ov_dout=0xA5C3F1 on the 24th transfer edge, cleared one cycle later.
REQ-032 Same word with i_din_valid toggling 1,0,1,0 -> identical ov_dout=0xA5C3F1; ov_bit_count increments only on valid cycles.
REQ-033 Backpressure: hold i_ready=0 for 5 cycles after completion -> ov_dout and o_dout_valid held and o_ready=0 for those cycles; the next word 0x123456 then receives correctly.
REQ-034 Assert i_rst_n=0 after 10 bits -> all outputs 0 and o_ready=i_en immediately; a full new word 0x00FFFF then assembles correctly with no spurious valid.
REQ-035 Drop i_en for 3 cycles mid-word with i_din_valid=1 -> o_ready=0, count frozen, final word unchanged.
REQ-036 LSB_FIRST=0, stream 0xA5C3F1 MSB-first -> ov_dout=0xA5C3F1.

Source files
------------

// File: rtl/deserializer_fsm.sv
// Serial-to-parallel word assembler with a valid/ready output handshake.
// Two-state FSM: collect LENGTH bits, then present the word until consumed.
module deserializer_fsm #(
  parameter int LENGTH    = 24,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_en,
  input  logic                       i_din,
  input  logic                       i_din_valid,
  output logic                       o_ready,
  output logic [LENGTH-1:0]          ov_dout,
  output logic                       o_dout_valid,
  input  logic                       i_ready,
  output logic [$clog2(LENGTH):0]    ov_bit_count
);

  localparam int CW = $clog2(LENGTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

  // One-hot codes leave 2'b00/2'b11 as illegal, recovered to S_RECV.
  typedef enum logic [1:0] {
    S_RECV = 2'b01,
    S_HOLD = 2'b10
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              ready_q;
  logic              ready_d;
  logic              valid_q;
  logic              valid_d;
  logic [LENGTH-1:0] dout_q;
  logic [LENGTH-1:0] dout_d;
  logic [LENGTH-1:0] sh_q;
  logic [LENGTH-1:0] sh_d;
  logic [LENGTH-1:0] sh_next;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_RECV;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      dout_q  <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      dout_q  <= dout_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    valid_d = valid_q;
    dout_d  = dout_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    if (LSB_FIRST)
      sh_next = {i_din, sh_q[LENGTH-1:1]};
    else
      sh_next = {sh_q[LENGTH-2:0], i_din};
    if (i_en) begin
      case (state_q)
        S_RECV: begin
          ready_d = 1'b1;
          if (i_din_valid && ready_q) begin
            sh_d = sh_next;
            if (cnt_q == LAST) begin
              dout_d  = sh_next;
              valid_d = 1'b1;
              ready_d = 1'b0;
              cnt_d   = '0;
              state_d = S_HOLD;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        S_HOLD: begin
          ready_d = 1'b0;
          if (i_ready) begin
            valid_d = 1'b0;
            ready_d = 1'b1;
            state_d = S_RECV;
          end
        end
        default: begin
          state_d = S_RECV;
          ready_d = 1'b1;
          valid_d = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign o_ready      = ready_q & i_en;
  assign ov_dout      = dout_q;
  assign o_dout_valid = valid_q;
  assign ov_bit_count = cnt_q;

endmodule

// File: tb/tb_deserializer_fsm.sv
// Bench for deserializer_fsm: LSB-first and MSB-first instances share
// stimulus; expected words travel through a scoreboard queue.
module tb_deserializer_fsm;

  localparam int L  = 24;
  localparam int CW = $clog2(L) + 1;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_en;
  logic          i_din;
  logic          i_din_valid;
  logic          i_ready;
  logic          rdy0, rdy1;
  logic          val0, val1;
  logic [L-1:0]  dout0, dout1;
  logic [CW-1:0] cnt0, cnt1;

  int passed = 0;
  int total  = 0;
  logic [L-1:0] exp_q[$];

  deserializer_fsm #(.LENGTH(L), .LSB_FIRST(1'b1)) dut_lsb (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
    .i_din(i_din), .i_din_valid(i_din_valid),
    .o_ready(rdy0), .ov_dout(dout0), .o_dout_valid(val0),
    .i_ready(i_ready), .ov_bit_count(cnt0)
  );

  deserializer_fsm #(.LENGTH(L), .LSB_FIRST(1'b0)) dut_msb (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
    .i_din(i_din), .i_din_valid(i_din_valid),
    .o_ready(rdy1), .ov_dout(dout1), .o_dout_valid(val1),
    .i_ready(i_ready), .ov_bit_count(cnt1)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Streams one word; checks count/valid after every edge.
  task automatic send_word(input logic [L-1:0] w, input bit msb,
                           input bit gaps, input int stall_at);
    logic          b;
    logic          v;
    logic          r;
    logic [L-1:0]  d;
    logic [CW-1:0] c;
    logic [L-1:0]  e;
    for (int i = 0; i < L; i++) begin
      b = msb ? w[L-1-i] : w[i];
      if (i == stall_at) begin
        i_en = 1'b0;
        i_din_valid = 1'b1;
        i_din = ~b;
        for (int k = 0; k < 3; k++) begin
          tick();
          r = msb ? rdy1 : rdy0;
          c = msb ? cnt1 : cnt0;
          total++;
          if (r !== 1'b0) $display("FAIL stall_ready got %b want 0", r);
          else passed++;
          total++;
          if (c !== CW'(i)) $display("FAIL stall_count got %0d want %0d", c, i);
          else passed++;
        end
        i_en = 1'b1;
      end
      i_din = b;
      i_din_valid = 1'b1;
      tick();
      v = msb ? val1 : val0;
      c = msb ? cnt1 : cnt0;
      d = msb ? dout1 : dout0;
      if (i < L - 1) begin
        total++;
        if (c !== CW'(i + 1) || v !== 1'b0)
          $display("FAIL bit_count got %0d/%b want %0d/0", c, v, i + 1);
        else passed++;
      end else begin
        e = exp_q.pop_front();
        total++;
        if (v !== 1'b1) $display("FAIL done_valid got %b want 1", v);
        else passed++;
        total++;
        if (d !== e) $display("FAIL done_word got %h want %h", d, e);
        else passed++;
        total++;
        if (c !== '0) $display("FAIL done_count got %0d want 0", c);
        else passed++;
      end
      if (gaps && i < L - 1) begin
        i_din_valid = 1'b0;
        i_din = ~b;
        tick();
        c = msb ? cnt1 : cnt0;
        total++;
        if (c !== CW'(i + 1)) $display("FAIL gap_count got %0d want %0d", c, i + 1);
        else passed++;
      end
    end
    i_din_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_en = 1'b1;
    i_din = 1'b0;
    i_din_valid = 1'b0;
    i_ready = 1'b1;
    #7;
    total++;
    if (rdy0 !== 1'b1 || val0 !== 1'b0 || dout0 !== '0 || cnt0 !== '0)
      $display("FAIL reset_state got r%b v%b d%h c%0d want r1 v0 d0 c0",
               rdy0, val0, dout0, cnt0);
    else passed++;
    tick();
    i_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [L-1:0] w = 24'hA5C3F1;
    i_ready = 1'b1;
    exp_q.push_back(w);
    send_word(w, 1'b0, 1'b0, -1);
    total++;
    if (rdy0 !== 1'b0) $display("FAIL hold_ready got %b want 0", rdy0);
    else passed++;
    tick();
    total++;
    if (val0 !== 1'b0 || rdy0 !== 1'b1 || dout0 !== w)
      $display("FAIL basic_clear got v%b r%b d%h want v0 r1 d%h", val0, rdy0, dout0, w);
    else passed++;
  endtask

  task automatic test_gaps();
    logic [L-1:0] w = 24'hA5C3F1;
    exp_q.push_back(w);
    send_word(w, 1'b0, 1'b1, -1);
    tick();
    total++;
    if (val0 !== 1'b0) $display("FAIL gaps_clear got %b want 0", val0);
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [L-1:0] w = 24'h5A3C96;
    i_ready = 1'b0;
    exp_q.push_back(w);
    send_word(w, 1'b0, 1'b0, -1);
    i_din_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_din = k[0];
      tick();
      total++;
      if (val0 !== 1'b1 || dout0 !== w || rdy0 !== 1'b0 || cnt0 !== '0)
        $display("FAIL bp_hold got v%b d%h r%b c%0d want v1 d%h r0 c0",
                 val0, dout0, rdy0, cnt0, w);
      else passed++;
    end
    i_din_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    total++;
    if (val0 !== 1'b0 || rdy0 !== 1'b1) $display("FAIL bp_release got v%b r%b want v0 r1", val0, rdy0);
    else passed++;
    exp_q.push_back(24'h123456);
    send_word(24'h123456, 1'b0, 1'b0, -1);
    tick();
  endtask

  task automatic test_reset_mid();
    logic [L-1:0] w = 24'hFFF0F0;
    for (int i = 0; i < 10; i++) begin
      i_din = w[i];
      i_din_valid = 1'b1;
      tick();
    end
    total++;
    if (cnt0 !== CW'(10)) $display("FAIL pre_reset_count got %0d want 10", cnt0);
    else passed++;
    i_rst_n = 1'b0;
    #1;
    total++;
    if (rdy0 !== 1'b1 || val0 !== 1'b0 || dout0 !== '0 || cnt0 !== '0)
      $display("FAIL midreset_state got r%b v%b d%h c%0d want r1 v0 d0 c0",
               rdy0, val0, dout0, cnt0);
    else passed++;
    i_en = 1'b0;
    #1;
    total++;
    if (rdy0 !== 1'b0) $display("FAIL reset_ready_en got %b want 0", rdy0);
    else passed++;
    i_en = 1'b1;
    i_din_valid = 1'b0;
    tick();
    i_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (val0 !== 1'b0 || cnt0 !== '0) $display("FAIL spurious_valid got v%b c%0d want v0 c0", val0, cnt0);
      else passed++;
    end
    exp_q.push_back(24'h00FFFF);
    send_word(24'h00FFFF, 1'b0, 1'b0, -1);
    tick();
  endtask

  task automatic test_enable();
    logic [L-1:0] w = 24'h3C5A69;
    exp_q.push_back(w);
    send_word(w, 1'b0, 1'b0, 7);
    tick();
    total++;
    if (dout0 !== w || val0 !== 1'b0) $display("FAIL en_final got d%h v%b want d%h v0", dout0, val0, w);
    else passed++;
  endtask

  task automatic test_msb_first();
    logic [L-1:0] w = 24'hA5C3F1;
    exp_q.push_back(w);
    send_word(w, 1'b1, 1'b0, -1);
    tick();
    total++;
    if (dout1 !== w || val1 !== 1'b0) $display("FAIL msb_final got d%h v%b want d%h v0", dout1, val1, w);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_backpressure();
    test_reset_mid();
    test_enable();
    test_msb_first();
    total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
